// File: rtl/chunked_stream_engine.sv
// Slices one WORDS-element vector into CHUNKS chunks, streams them through a
// fixed-latency compute unit and reassembles the results in order.
module chunked_stream_engine #(
  parameter int W     = 8,
  parameter int WORDS = 16,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  output logic               ready_i,
  input  logic [WORDS*W-1:0] in,
  output logic               valid_o,
  input  logic               ready_o,
  output logic [WORDS*W-1:0] out,
  output logic               cmp_valid_o,
  output logic [N*W-1:0]     cmp_data_o,
  input  logic               cmp_valid_i,
  input  logic [N*W-1:0]     cmp_data_i,
  output logic               stray_o
);

  localparam int CHUNKS = WORDS / N;
  localparam int IW     = $clog2(CHUNKS + 1);
  localparam int CW     = N * W;
  localparam int VW     = WORDS * W;

  if ((WORDS % N) != 0 || N > WORDS) begin : g_bad_params
    $error("chunked_stream_engine: WORDS must be a multiple of N and N <= WORDS");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] issue_idx_q, issue_idx_d;
  logic [IW-1:0] recv_idx_q, recv_idx_d;
  logic [VW-1:0] in_q, in_d;
  logic [VW-1:0] asm_q, asm_d;
  logic          stray_q, stray_d;

  logic accept, recv_ok, recv_last, last_issue;

  assign accept     = ready_i & valid_i;
  assign last_issue = (issue_idx_q == IW'(CHUNKS - 1));
  // A result is only legal while a vector is in flight and chunks remain outstanding.
  assign recv_ok    = cmp_valid_i && (state_q == ISSUE || state_q == WAIT)
                      && (recv_idx_q != IW'(CHUNKS));
  assign recv_last  = recv_ok && (recv_idx_q == IW'(CHUNKS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (last_issue) state_d = recv_last ? OUT : WAIT;
      WAIT:    if (recv_last) state_d = OUT;
      OUT:     if (ready_o) state_d = valid_i ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    ready_i     = 1'b0;
    valid_o     = 1'b0;
    cmp_valid_o = 1'b0;
    cmp_data_o  = '0;
    if (!reset) begin
      case (state_q)
        IDLE:  ready_i = 1'b1;
        ISSUE: begin
          cmp_valid_o = 1'b1;
          cmp_data_o  = in_q[int'(issue_idx_q)*CW +: CW];
        end
        OUT: begin
          valid_o = 1'b1;
          ready_i = ready_o;
        end
        default: ;
      endcase
    end
  end

  assign out     = asm_q;
  assign stray_o = stray_q;

  always_comb begin
    in_d        = in_q;
    issue_idx_d = issue_idx_q;
    recv_idx_d  = recv_idx_q;
    asm_d       = asm_q;
    stray_d     = stray_q | (cmp_valid_i & ~recv_ok);
    if (state_q == ISSUE) issue_idx_d = issue_idx_q + IW'(1);
    if (recv_ok) begin
      asm_d[int'(recv_idx_q)*CW +: CW] = cmp_data_i;
      recv_idx_d                       = recv_idx_q + IW'(1);
    end
    if (accept) begin
      in_d        = in;
      issue_idx_d = '0;
      recv_idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_idx_q <= '0;
      recv_idx_q  <= '0;
      in_q        <= '0;
      asm_q       <= '0;
      stray_q     <= 1'b0;
    end else begin
      issue_idx_q <= issue_idx_d;
      recv_idx_q  <= recv_idx_d;
      in_q        <= in_d;
      asm_q       <= asm_d;
      stray_q     <= stray_d;
    end
  end

endmodule

// File: tb/tb_chunked_stream_engine.sv
// Bench for chunked_stream_engine: a delay-line compute model (+2 per element),
// an output scoreboard, a vector table and cycle-exact corner-case sequences.
`timescale 1ns/1ps
module tb_chunked_stream_engine;

  localparam int W     = 8;
  localparam int WORDS = 16;
  localparam int N     = 4;
  localparam int VW    = WORDS * W;
  localparam int CW    = N * W;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t vin;
    vec_t exp;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_i = 1'b0, ready_o = 1'b0;
  logic ready_i, valid_o, cmp_valid_o, cmp_valid_i, stray_o;
  vec_t in_v = '0, out_v;
  logic [CW-1:0] cmp_data_o, cmp_data_i;

  int            lat   = 1;
  logic          inj_v = 1'b0;
  logic [CW-1:0] inj_d = '0;
  logic          pipe_v [16];
  logic [CW-1:0] pipe_d [16];

  logic v2_valid_i = 1'b0, v2_ready_o = 1'b1;
  logic v2_ready_i, v2_valid_o, v2_cmp_valid_o, v2_stray_o;
  vec_t v2_in = '0, v2_out, v2_cmp_data_o;
  logic p2_v [2];
  vec_t p2_d [2];

  vec_t sb[$];
  int   n_pass = 0, n_total = 0;
  rec_t tbl [3];
  vec_t ramp;

  always #5 clk = ~clk;

  chunked_stream_engine #(.W(W), .WORDS(WORDS), .N(N)) u_dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .ready_i(ready_i), .in(in_v),
    .valid_o(valid_o), .ready_o(ready_o), .out(out_v),
    .cmp_valid_o(cmp_valid_o), .cmp_data_o(cmp_data_o),
    .cmp_valid_i(cmp_valid_i), .cmp_data_i(cmp_data_i),
    .stray_o(stray_o)
  );

  chunked_stream_engine #(.W(W), .WORDS(WORDS), .N(WORDS)) u_one (
    .clk(clk), .reset(reset),
    .valid_i(v2_valid_i), .ready_i(v2_ready_i), .in(v2_in),
    .valid_o(v2_valid_o), .ready_o(v2_ready_o), .out(v2_out),
    .cmp_valid_o(v2_cmp_valid_o), .cmp_data_o(v2_cmp_data_o),
    .cmp_valid_i(p2_v[1]), .cmp_data_i(p2_d[1]),
    .stray_o(v2_stray_o)
  );

  function automatic vec_t plus2v(input vec_t v);
    vec_t r;
    for (int e = 0; e < WORDS; e++) r[e*W +: W] = v[e*W +: W] + 8'd2;
    return r;
  endfunction

  function automatic logic [CW-1:0] plus2c(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    for (int e = 0; e < N; e++) r[e*W +: W] = c[e*W +: W] + 8'd2;
    return r;
  endfunction

  // Compute unit models: fixed-latency delay lines with no backpressure.
  always @(posedge clk) begin
    for (int i = 15; i > 0; i--) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    pipe_v[0] <= cmp_valid_o;
    pipe_d[0] <= plus2c(cmp_data_o);
    p2_v[1]   <= p2_v[0];
    p2_d[1]   <= p2_d[0];
    p2_v[0]   <= v2_cmp_valid_o;
    p2_d[0]   <= plus2v(v2_cmp_data_o);
  end

  assign cmp_valid_i = inj_v | pipe_v[lat-1];
  assign cmp_data_i  = inj_v ? inj_d : pipe_d[lat-1];

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, vec_t'(act), vec_t'(exp));
  endtask

  always @(negedge clk) begin
    if (!reset && valid_o && ready_o) begin
      check_bit("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) check("sb_out", out_v, sb.pop_front());
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_i = 1'b0; ready_o = 1'b1; inj_v = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check_bit("rst_ready_i", ready_i, 1'b0);
    check_bit("rst_valid_o", valid_o, 1'b0);
    check_bit("rst_cmp_valid_o", cmp_valid_o, 1'b0);
    check_bit("rst_stray_o", stray_o, 1'b0);
    check("rst_out", out_v, '0);
    nxt();
    reset = 1'b0;
    sb.delete();
  endtask

  // Presents v until accepted; returns one cycle after the accepting cycle.
  task automatic send_vec(input vec_t v);
    bit done = 1'b0;
    valid_i = 1'b1;
    in_v    = v;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (ready_i) begin
        sb.push_back(plus2v(v));
        done = 1'b1;
      end
      nxt();
    end
    valid_i = 1'b0;
    check_bit("send_accepted", done, 1'b1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
    check("drain", vec_t'(sb.size()), '0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc [3];
    int idx;
    for (int e = 0; e < WORDS; e++) ramp[e*W +: W] = 8'(e);
    for (int t = 0; t < 3; t++)
      for (int e = 0; e < WORDS; e++) tbl[t].vin[e*W +: W] = 8'($urandom_range(0, 255));
    tbl[1].vin[7:0]       = 8'hFF;
    tbl[1].vin[VW-1 -: W] = 8'hFE;
    for (int t = 0; t < 3; t++) tbl[t].exp = plus2v(tbl[t].vin);

    // L=1: issue cycles 1..4, valid_o at cycle 6.
    do_reset();
    lat = 1; ready_o = 1'b1;
    @(negedge clk);
    check_bit("t1_first_ready", ready_i, 1'b1);
    nxt();
    send_vec(ramp);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check_bit("t1_cmp_valid", cmp_valid_o, c <= 4);
      if (c <= 4) check("t1_chunk", vec_t'(cmp_data_o), vec_t'(ramp[(c-1)*CW +: CW]));
      else        check("t1_chunk_zero", vec_t'(cmp_data_o), '0);
      check_bit("t1_valid_o", valid_o, c == 6);
      check_bit("t1_ready_i", ready_i, c >= 6);
      nxt();
    end
    wait_drain();

    // L=5 with downstream stalled until cycle 13.
    do_reset();
    lat = 5; ready_o = 1'b0;
    send_vec(tbl[1].vin);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check_bit("t2_valid_o", valid_o, c >= 10 && c <= 13);
      if (c >= 10 && c <= 12) begin
        check("t2_out_held", out_v, tbl[1].exp);
        check_bit("t2_ready_i_blocked", ready_i, 1'b0);
      end
      if (c == 14) check_bit("t2_idle_ready", ready_i, 1'b1);
      nxt();
      if (c == 12) ready_o = 1'b1;
    end
    wait_drain();

    // Back-to-back table: valid_i held high, accepts at cycles 0, 6, 12.
    do_reset();
    lat = 1; ready_o = 1'b1;
    idx = 0; valid_i = 1'b1; in_v = tbl[0].vin;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      @(negedge clk);
      if (ready_i) begin
        sb.push_back(tbl[idx].exp);
        acc[idx] = c;
        idx++;
      end
      nxt();
      if (idx < 3) in_v = tbl[idx].vin;
      else         valid_i = 1'b0;
    end
    valid_i = 1'b0;
    check("t3_accepted", vec_t'(idx), vec_t'(3));
    check("t3_gap1", vec_t'(acc[1] - acc[0]), vec_t'(6));
    check("t3_gap2", vec_t'(acc[2] - acc[1]), vec_t'(6));
    wait_drain();

    // Reset after three issues; late results must flag stray_o.
    do_reset();
    lat = 5; ready_o = 1'b1;
    send_vec(tbl[2].vin);
    nxt(); nxt(); nxt();
    reset = 1'b1;
    @(negedge clk);
    check_bit("t4_rst_no_issue", cmp_valid_o, 1'b0);
    nxt();
    reset = 1'b0;
    sb.delete();
    for (int c = 5; c <= 11; c++) begin
      @(negedge clk);
      check_bit("t4_valid_o", valid_o, 1'b0);
      if (c == 5) check_bit("t4_stray_early", stray_o, 1'b0);
      if (c == 9) check_bit("t4_stray_set", stray_o, 1'b1);
      nxt();
    end
    send_vec(tbl[0].vin);
    wait_drain();
    @(negedge clk);
    check_bit("t4_stray_sticky", stray_o, 1'b1);
    nxt();

    // Stray pulse while holding a result in OUT.
    do_reset();
    lat = 1; ready_o = 1'b0;
    send_vec(tbl[1].vin);
    repeat (5) nxt();
    @(negedge clk);
    check_bit("t5_valid_o", valid_o, 1'b1);
    check_bit("t5_stray_clear", stray_o, 1'b0);
    nxt();
    inj_v = 1'b1; inj_d = 32'h0000_00FF;
    @(negedge clk);
    nxt();
    inj_v = 1'b0;
    @(negedge clk);
    check_bit("t5_stray_set", stray_o, 1'b1);
    check_bit("t5_still_valid", valid_o, 1'b1);
    check("t5_out_unchanged", out_v, tbl[1].exp);
    nxt();
    ready_o = 1'b1;
    wait_drain();

    // CHUNKS = 1 instance, L=2: one issue at cycle 1, valid_o at cycle 4.
    do_reset();
    v2_valid_i = 1'b1; v2_in = tbl[2].vin;
    @(negedge clk);
    check_bit("t6_ready", v2_ready_i, 1'b1);
    nxt();
    v2_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_bit("t6_cmp_valid", v2_cmp_valid_o, c == 1);
      if (c == 1) check("t6_chunk", v2_cmp_data_o, tbl[2].vin);
      check_bit("t6_valid_o", v2_valid_o, c == 4);
      if (c == 4) check("t6_out", v2_out, tbl[2].exp);
      nxt();
    end
    check_bit("t6_stray", v2_stray_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
